// File: rtl/huffman_serial_decoder.sv
// Serial Huffman decoder: shifts in codeword bits MSB first and
// matches them against the sorted length/codeword tables.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   length           packed length table, DATA_WIDTH per entry
//   codeword         packed codeword table, MAXHIGHT per entry
//   enable           decode enable (low pauses)
//   start            pulse: clear counters, begin a stream
//   expected_count   number of symbols in the stream
//   serial_in        serial data bit
//   bit_valid        serial_in qualifier
//   symbol_index     decoded table index
//   symbol_valid     one-cycle strobe for symbol_index
//   symbol_count     symbols decoded so far (saturating)
//   error            sticky invalid-codeword flag
//   done             stream complete
module huffman_serial_decoder #(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SYMBOLS = 10,
    parameter int ADDR_WIDTH    = 4,
    parameter int MAXHIGHT      = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] length,
    input  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   codeword,
    input  logic                                enable,
    input  logic                                start,
    input  logic [ADDR_WIDTH+7:0]               expected_count,
    input  logic                                serial_in,
    input  logic                                bit_valid,
    output logic [ADDR_WIDTH-1:0]               symbol_index,
    output logic                                symbol_valid,
    output logic [ADDR_WIDTH+7:0]               symbol_count,
    output logic                                error,
    output logic                                done
);

    localparam int CNTW = $clog2(MAXHIGHT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state, state_n;

    logic [MAXHIGHT-1:0]   acc, acc_n;
    logic [CNTW-1:0]       bitcnt, cnt_n;
    logic [ADDR_WIDTH-1:0] idx_n;
    logic                  valid_n;
    logic [ADDR_WIDTH+7:0] count_n;
    logic                  err_n;
    logic                  done_n;

    logic [MAXHIGHT-1:0]   next_acc;
    logic [CNTW-1:0]       next_cnt;
    logic [MAXHIGHT-1:0]   mask;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] hit_idx;
    logic [ADDR_WIDTH+7:0] count_inc;

    assign next_acc = {acc[MAXHIGHT-2:0], serial_in};
    assign next_cnt = bitcnt + 1'b1;

    // Saturate rather than wrap the symbol counter.
    assign count_inc = (&symbol_count) ? symbol_count
                                       : symbol_count + 1'b1;

    // Only the low next_cnt bits of the accumulator are compared.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXHIGHT; i++) begin
            mask[i] = (i < 32'(next_cnt));
        end
    end

    // Scan downward so the lowest matching index wins.
    // Length 0 or > MAXHIGHT can never equal next_cnt.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = TOTAL_SYMBOLS - 1; k >= 0; k--) begin
            if (length[k*DATA_WIDTH +: DATA_WIDTH]
                    == DATA_WIDTH'(next_cnt) &&
                ((codeword[k*MAXHIGHT +: MAXHIGHT] ^ next_acc)
                    & mask) == '0) begin
                hit     = 1'b1;
                hit_idx = ADDR_WIDTH'(k);
            end
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = bitcnt;
        idx_n   = symbol_index;
        valid_n = 1'b0;
        count_n = symbol_count;
        err_n   = error;
        done_n  = done;
        if (start) begin
            acc_n   = '0;
            cnt_n   = '0;
            count_n = '0;
            err_n   = 1'b0;
            if (expected_count == '0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = SHIFT;
                done_n  = 1'b0;
            end
        end else begin
            case (state)
                SHIFT: begin
                    if (enable && bit_valid) begin
                        if (hit) begin
                            idx_n   = hit_idx;
                            valid_n = 1'b1;
                            acc_n   = '0;
                            cnt_n   = '0;
                            count_n = count_inc;
                            if (count_inc == expected_count) begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end else if (next_cnt == CNTW'(MAXHIGHT)) begin
                            err_n   = 1'b1;
                            state_n = ERR;
                        end else begin
                            acc_n = next_acc;
                            cnt_n = next_cnt;
                        end
                    end
                end
                DONE:    done_n = 1'b1;
                ERR:     err_n  = 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            bitcnt       <= '0;
            symbol_index <= '0;
            symbol_valid <= 1'b0;
            symbol_count <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
        end else begin
            acc          <= acc_n;
            bitcnt       <= cnt_n;
            symbol_index <= idx_n;
            symbol_valid <= valid_n;
            symbol_count <= count_n;
            error        <= err_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_huffman_serial_decoder.sv
// Directed bench for huffman_serial_decoder.
// Table-driven bit vectors plus hand sequences for restart/reset.
module tb_huffman_serial_decoder;

    localparam int DW = 8;
    localparam int NS = 10;
    localparam int AW = 4;
    localparam int MH = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] length;
    logic [NS*MH-1:0] codeword;
    logic             enable;
    logic             start;
    logic [AW+7:0]    expected_count;
    logic             serial_in;
    logic             bit_valid;
    logic [AW-1:0]    symbol_index;
    logic             symbol_valid;
    logic [AW+7:0]    symbol_count;
    logic             error;
    logic             done;

    int checks = 0;
    int failures = 0;

    huffman_serial_decoder #(
        .DATA_WIDTH(DW), .TOTAL_SYMBOLS(NS),
        .ADDR_WIDTH(AW), .MAXHIGHT(MH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .length(length),
        .codeword(codeword), .enable(enable), .start(start),
        .expected_count(expected_count), .serial_in(serial_in),
        .bit_valid(bit_valid), .symbol_index(symbol_index),
        .symbol_valid(symbol_valid), .symbol_count(symbol_count),
        .error(error), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sbit;
        bit       bv;
        bit       en;
        bit       ev;
        bit [3:0] ei;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit b, input bit bv, input bit en,
                        input bit ev, input bit [3:0] ei,
                        input string nm);
        @(negedge clk);
        serial_in = b;
        bit_valid = bv;
        enable    = en;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, 16'(symbol_valid), 16'(ev));
        if (ev) chk({nm, "_index"}, 16'(symbol_index), 16'(ei));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_valid = 1'b0;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW+7:0] n);
        @(negedge clk);
        start          = 1'b1;
        expected_count = n;
        bit_valid      = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_entry(input int k, input int len, input int cw);
        length[k*DW +: DW]   = DW'(len);
        codeword[k*MH +: MH] = MH'(cw);
    endtask

    // Prefix-free table; entry 5 duplicates entry 0 to exercise
    // lowest-index priority.
    task automatic load_basic_table();
        length   = '0;
        codeword = '0;
        set_entry(0, 1, 0);
        set_entry(1, 2, 2);
        set_entry(2, 3, 6);
        set_entry(3, 3, 7);
        set_entry(5, 1, 0);
    endtask

    task automatic add(input bit b, input bit bv, input bit en,
                       input bit ev, input bit [3:0] ei);
        vec_t v;
        v.sbit = b;
        v.bv   = bv;
        v.en   = en;
        v.ev   = ev;
        v.ei   = ei;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        start          = 1'b0;
        expected_count = '0;
        serial_in      = 1'b0;
        bit_valid      = 1'b0;
        load_basic_table();

        // Basic stream 0,10,110,111
        add(0, 1, 1, 1, 0);
        add(1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 1);
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 2);
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 3);
        // Same stream with stalls (entries 9..)
        add(0, 1, 1, 1, 0);
        add(1, 1, 1, 0, 0);
        add(1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 1);
        add(1, 1, 1, 0, 0);
        add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 2);
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 3);

        #12;
        chk("rst_valid", 16'(symbol_valid), 16'h0);
        chk("rst_count", 16'(symbol_count), 16'h0);
        chk("rst_done",  16'(done),         16'h0);
        chk("rst_error", 16'(error),        16'h0);
        rst_n = 1'b1;

        // Bits without start are ignored.
        for (int i = 0; i < 4; i++) step(1'(i), 1, 1, 0, 0, "idle");
        chk("idle_count", 16'(symbol_count), 16'h0);
        chk("idle_done",  16'(done),         16'h0);
        chk("idle_error", 16'(error),        16'h0);

        // Basic decode
        do_start(4);
        for (int i = 0; i < 9; i++)
            step(vecs[i].sbit, vecs[i].bv, vecs[i].en,
                 vecs[i].ev, vecs[i].ei, $sformatf("basic%0d", i));
        chk("basic_count", 16'(symbol_count), 16'd4);
        idle_cycle();
        chk("basic_done", 16'(done), 16'h1);
        chk("basic_idx_hold", 16'(symbol_index), 16'd3);

        // Bits after done are ignored.
        step(0, 1, 1, 0, 0, "post_done0");
        step(0, 1, 1, 0, 0, "post_done1");
        chk("post_done_count", 16'(symbol_count), 16'd4);

        // Restart: 111,0 -> 3,0
        do_start(2);
        chk("restart_count", 16'(symbol_count), 16'd0);
        chk("restart_done",  16'(done),         16'd0);
        step(1, 1, 1, 0, 0, "rs0");
        step(1, 1, 1, 0, 0, "rs1");
        step(1, 1, 1, 1, 3, "rs2");
        step(0, 1, 1, 1, 0, "rs3");
        idle_cycle();
        chk("restart_done2",  16'(done),         16'h1);
        chk("restart_count2", 16'(symbol_count), 16'd2);

        // Stall handling
        do_start(4);
        for (int i = 9; i < vecs.size(); i++)
            step(vecs[i].sbit, vecs[i].bv, vecs[i].en,
                 vecs[i].ev, vecs[i].ei, $sformatf("stall%0d", i));
        idle_cycle();
        chk("stall_count", 16'(symbol_count), 16'd4);
        chk("stall_done",  16'(done),         16'h1);

        // Invalid codeword: no entry matches runs of ones.
        set_entry(3, 3, 5);
        do_start(4);
        for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 0, "inv");
        chk("inv_err_early", 16'(error), 16'h0);
        step(1, 1, 1, 0, 0, "inv10");
        chk("inv_err", 16'(error), 16'h1);
        step(0, 1, 1, 0, 0, "inv_ign0");
        step(0, 1, 1, 0, 0, "inv_ign1");
        chk("inv_err_sticky", 16'(error), 16'h1);
        chk("inv_count", 16'(symbol_count), 16'd0);
        do_start(4);
        chk("inv_clear", 16'(error), 16'h0);
        load_basic_table();

        // expected_count == 0 finishes immediately.
        do_start(0);
        chk("zero_done", 16'(done), 16'h1);
        step(0, 1, 1, 0, 0, "zero_ign");

        // Async reset mid-codeword.
        do_start(4);
        step(1, 1, 1, 0, 0, "ar0");
        step(1, 1, 1, 0, 0, "ar1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_index", 16'(symbol_index), 16'd0);
        chk("ar_count", 16'(symbol_count), 16'd0);
        chk("ar_done",  16'(done),         16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 1, 0, 0, "ar_nostart");
        do_start(1);
        step(0, 1, 1, 1, 0, "ar_clean");
        chk("ar_clean_done", 16'(done), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
